// File: rtl/instr_fetch.sv
// Instruction fetch stage for KGPRISC: PC -> imem req/ack -> instr valid/ready to decode.
// Optional hung-fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        stall,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [31:0] imem_addr_r;
  logic [31:0] addr_nxt_s;
  logic [31:0] instr_r;
  logic [31:0] instr_nxt_s;
  logic [31:0] fault_pc_r;
  logic [31:0] fault_pc_nxt_s;
  logic        req_r;
  logic        valid_r;
  logic        stall_r;
  logic        fault_r;
  logic        tmo_expire_s;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt_r;
  logic       waiting_s;

  assign waiting_s    = (state_r == ST_REQ) || (state_r == ST_DROP);
  assign tmo_expire_s = waiting_s && (tmo_cnt_r == 8'(TIMEOUT_CYCLES - 32'd1));

  // Watchdog: restarts on every entry to REQ/DROP, counts unacknowledged cycles.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      tmo_cnt_r <= 8'd0;
    end else if (((state_nxt_s == ST_REQ) || (state_nxt_s == ST_DROP)) && (state_nxt_s != state_r)) begin
      tmo_cnt_r <= 8'd0;
    end else if (waiting_s && !imem_ack) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  // No watchdog: legal TIMEOUT_CYCLES is never 0, so this is a constant 0.
  assign tmo_expire_s = (TIMEOUT_CYCLES == 32'd0);
`endif

  // Next-state and datapath load decisions.
  always_comb begin
    state_nxt_s    = state_r;
    addr_nxt_s     = imem_addr_r;
    instr_nxt_s    = instr_r;
    fault_pc_nxt_s = fault_pc_r;
    case (state_r)
      ST_IDLE: begin
        if (fetch_en) begin
          if (pc[1:0] == 2'b00) begin
            state_nxt_s = ST_REQ;
            addr_nxt_s  = pc;
          end else begin
            state_nxt_s    = ST_FAULT;
            fault_pc_nxt_s = pc;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (flush) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_HOLD;
            instr_nxt_s = imem_rdata;
          end
        end else if (flush) begin
          // A request already on the bus cannot be withdrawn; wait it out.
          state_nxt_s = ST_DROP;
        end else if (tmo_expire_s) begin
          state_nxt_s    = ST_FAULT;
          fault_pc_nxt_s = imem_addr_r;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_nxt_s = ST_IDLE;
        end else if (tmo_expire_s) begin
          state_nxt_s    = ST_FAULT;
          fault_pc_nxt_s = imem_addr_r;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (instr_ready) begin
          if (fetch_en) begin
            if (pc[1:0] == 2'b00) begin
              state_nxt_s = ST_REQ;
              addr_nxt_s  = pc;
            end else begin
              state_nxt_s    = ST_FAULT;
              fault_pc_nxt_s = pc;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and output flags decoded from the next state.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_r     <= ST_IDLE;
      imem_addr_r <= 32'd0;
      instr_r     <= 32'd0;
      fault_pc_r  <= 32'd0;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
      stall_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      imem_addr_r <= addr_nxt_s;
      instr_r     <= instr_nxt_s;
      fault_pc_r  <= fault_pc_nxt_s;
      req_r       <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DROP);
      valid_r     <= (state_nxt_s == ST_HOLD);
      stall_r     <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HOLD);
      fault_r     <= (state_nxt_s == ST_FAULT);
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = imem_addr_r;
  assign instr       = instr_r;
  assign opcode      = instr_r[31:26];
  assign instr_valid = valid_r;
  assign stall       = stall_r;
  assign fetch_fault = fault_r;
  assign fault_pc    = fault_pc_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; timeout case follows FETCH_TIMEOUT_EN.
module tb_instr_fetch;

  logic        clk;
  logic        start;
  logic [31:0] pc;
  logic        fetch_en;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int checks_cnt;
  int fail_cnt;

  instr_fetch #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .start       (start),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stall       (stall),
    .fetch_fault (fetch_fault),
    .fault_pc    (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic req, input logic vld,
                           input logic stl, input logic flt);
    chk_val({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    chk_val({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, vld});
    chk_val({tag, ".stall"}, {31'd0, stall},       {31'd0, stl});
    chk_val({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, flt});
  endtask

  task automatic chk_reset_state(input string tag);
    chk_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val({tag, ".addr"},   imem_addr, 32'd0);
    chk_val({tag, ".instr"},  instr, 32'd0);
    chk_val({tag, ".opcode"}, {26'd0, opcode}, 32'd0);
    chk_val({tag, ".fpc"},    fault_pc, 32'd0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
  endtask

  initial begin
    checks_cnt  = 0;
    fail_cnt    = 0;
    start       = 1'b0;
    pc          = 32'd0;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;

    tick();
    tick();
    chk_reset_state("reset");
    start = 1'b1;
    tick();
    chk_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic fetch with one wait cycle before ack.
    pc = 32'h0000_0010; fetch_en = 1'b1; instr_ready = 1'b1;
    tick();
    chk_flags("basic.req", 1'b1, 1'b0, 1'b1, 1'b0);
    chk_val("basic.addr", imem_addr, 32'h0000_0010);
    fetch_en = 1'b0;
    tick();
    chk_flags("basic.wait", 1'b1, 1'b0, 1'b1, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h4000_0020;
    tick();
    imem_ack = 1'b0;
    chk_flags("basic.hold", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("basic.instr", instr, 32'h4000_0020);
    chk_val("basic.opcode", {26'd0, opcode}, 32'h0000_0010);
    tick();
    chk_flags("basic.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("basic.instr_kept", instr, 32'h4000_0020);

    // Back-to-back fetches with zero-wait ack: valid every other cycle.
    pc = 32'h0; fetch_en = 1'b1; instr_ready = 1'b1; imem_ack = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_flags($sformatf("b2b%0d.req", i), 1'b1, 1'b0, 1'b1, 1'b0);
      chk_val($sformatf("b2b%0d.addr", i), imem_addr, 32'(4 * i));
      imem_rdata = 32'h1000_0000 + 32'(i);
      tick();
      chk_flags($sformatf("b2b%0d.hold", i), 1'b0, 1'b1, 1'b0, 1'b0);
      chk_val($sformatf("b2b%0d.instr", i), instr, 32'h1000_0000 + 32'(i));
      if (i < 2) begin
        pc = 32'(4 * (i + 1));
      end else begin
        fetch_en = 1'b0;
      end
      tick();
    end
    imem_ack = 1'b0;
    chk_flags("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush before ack: request persists, late data is discarded.
    pc = 32'h30; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_flags("flush.drop", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_flags("flush.drop2", 1'b1, 1'b0, 1'b1, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk_flags("flush.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("flush.instr_kept", instr, 32'h1000_0002);
    pc = 32'h20; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk_val("flush.addr20", imem_addr, 32'h20);
    imem_ack = 1'b1; imem_rdata = 32'h8C00_0004;
    tick();
    imem_ack = 1'b0;
    chk_flags("flush.hold20", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("flush.instr20", instr, 32'h8C00_0004);
    tick();

    // Flush coinciding with ack drops the data.
    pc = 32'h40; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678; flush = 1'b1;
    tick();
    imem_ack = 1'b0; flush = 1'b0;
    chk_flags("flushack", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("flushack.instr", instr, 32'h8C00_0004);

    // HOLD waits for ready; flush beats fetch_en.
    pc = 32'h44; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFC00_0000; instr_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    tick();
    chk_flags("hold.wait", 1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("hold.opcode", {26'd0, opcode}, 32'h0000_003F);
    flush = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1; pc = 32'h48;
    tick();
    flush = 1'b0; fetch_en = 1'b0;
    chk_flags("hold.flush", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("hold.addr_kept", imem_addr, 32'h44);

    // Misaligned PC: no request, sticky fault.
    pc = 32'h6; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk_flags("mis", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_val("mis.fpc", fault_pc, 32'h6);
    pc = 32'h50; fetch_en = 1'b1; flush = 1'b1;
    tick();
    tick();
    fetch_en = 1'b0; flush = 1'b0;
    chk_flags("mis.sticky", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_val("mis.fpc_kept", fault_pc, 32'h6);
    do_reset();
    chk_reset_state("mis.cleared");

    // Unacknowledged request.
    pc = 32'h80; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk_flags("tmo.req1", 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FETCH_TIMEOUT_EN
    tick();
    tick();
    tick();
    chk_flags("tmo.req4", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_flags("tmo.fault", 1'b0, 1'b0, 1'b1, 1'b1);
    chk_val("tmo.fpc", fault_pc, 32'h80);
`else
    repeat (1000) tick();
    chk_flags("notmo.req", 1'b1, 1'b0, 1'b1, 1'b0);
    chk_val("notmo.addr", imem_addr, 32'h80);
`endif
    do_reset();

    // Async reset in the middle of a request.
    pc = 32'h90; fetch_en = 1'b1; imem_rdata = 32'hAAAA_5555;
    tick();
    fetch_en = 1'b0;
    tick();
    chk_flags("areset.pre", 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    start = 1'b0;
    #1;
    chk_reset_state("areset");
    tick();
    start = 1'b1;
    tick();
    chk_flags("areset.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
